uart_transmissor: RTL and testbench
===================================

Name: uart_transmissor

Overview:
- 8N1 UART transmitter; the serial stage directly downstream of the event senders (end-game, payload controllers).
- Accepts one byte per `iniciar_envio` pulse and serialises it on `tx`, LSB first.
- Reports `uart_ocupado` to the senders so they can pace their bytes, and pulses `envio_concluido` at the end of each frame.

Parameters:
- CLOCK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate in bit/s.
- CLKS_PER_BIT, CLOCK_FREQ/BAUD_RATE (integer division), clock cycles per serial bit. Must be >= 2; elaboration fails otherwise.

Ports:
- clock  input  1  system clock; everything is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- iniciar_envio  input  1  one-cycle request to transmit `dado_entrada`.
- dado_entrada  input  8  byte to send; sampled only in the accept cycle.
- tx  output  1  serial line; idles high.
- uart_ocupado  output  1  high while a frame is in progress.
- envio_concluido  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset values: tx=1, uart_ocupado=0, envio_concluido=0, state=IDLE, all counters 0. Reset mid-frame aborts the frame immediately; tx returns to 1 on the next edge.
- States: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
- A baud counter runs 0..CLKS_PER_BIT-1 in every state except IDLE. Reaching CLKS_PER_BIT-1 ends the current bit and clears the counter.
- IDLE:
  - tx=1.
  - If iniciar_envio=1, latch dado_entrada into the shift register and go to START.
  - The accept cycle is cycle 0. uart_ocupado reads 1 from cycle 1 onward (registered as state != IDLE).
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift[0] for CLKS_PER_BIT cycles, then shift right and increment the 3-bit index.
  - After index 7 completes, go to PARITY if enabled, else STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
- In the cycle that returns to IDLE:
  - envio_concluido=1 for exactly one cycle.
  - uart_ocupado=0.
  - A new iniciar_envio is accepted in the following cycle. Back-to-back frames therefore have zero idle bit-time beyond a single cycle.
- Frame timing:
  - tx falls on cycle 1.
  - Frame length is 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
  - envio_concluido asserts on cycle 10*CLKS_PER_BIT+1 (no parity).
- iniciar_envio while uart_ocupado=1 is ignored: no latch, no queueing, no effect on the current frame. dado_entrada changes during a frame have no effect.
- iniciar_envio held high continuously starts a new frame each time IDLE is reached.
- tx is driven from a register; there are no combinational glitches on the line.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the latched byte) for CLKS_PER_BIT cycles.
  - Frame is 11 bits; envio_concluido shifts by CLKS_PER_BIT cycles.
- Undefined: no PARITY state and no parity logic; frame is 8N1 (10 bits).

Test Plan:
- All scenarios use CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, so CLKS_PER_BIT=10.
- Reset then idle for 50 cycles -> tx=1, uart_ocupado=0, envio_concluido=0 throughout.
- Send 0xAE (no parity) -> tx sequence, each value held 10 cycles: start 0, data 0,1,1,1,0,1,0,1, stop 1. uart_ocupado high for cycles 1..100. envio_concluido pulses once at cycle 101.
- With UART_TX_PARITY_EN, send 0xAE -> parity bit 1 (five ones) after bit 7. envio_concluido at cycle 111. Send 0x03 -> parity bit 0.
- Pulse iniciar_envio with 0x55 at cycle 35 of a 0xAE frame -> no change to 0xAE bits, and no second frame afterwards.
- Assert iniciar_envio with 0x81 in the cycle after envio_concluido -> new start bit begins one cycle later. Decoded bytes are 0xAE then 0x81.
- Assert reset at cycle 45 of a frame -> tx=1 and uart_ocupado=0 on the next edge, no envio_concluido. A subsequent send of 0x0F completes correctly.

Source files
------------

// File: rtl/uart_transmissor.sv
// rtl/uart_transmissor.sv - 8N1 UART transmitter, LSB first, registered tx line
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
`timescale 1ns/1ps
module uart_transmissor #(
    parameter int CLOCK_FREQ   = 50_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar_envio,
    input  logic [7:0] dado_entrada,
    output logic       tx,
    output logic       uart_ocupado,
    output logic       envio_concluido
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_transmissor: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       shift_q;
    logic [2:0]       idx_q;
    logic             tx_q;
    logic             busy_q;
    logic             done_q;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`endif

    logic bit_end;
    assign bit_end = (cnt_q == CNT_LAST);

    // tx_q always carries the level of the bit being entered, so the line changes
    // on the same edge as the state and never passes through combinational logic.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE) begin
                cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    tx_q  <= 1'b1;
                    if (iniciar_envio) begin
                        shift_q  <= dado_entrada;
                        idx_q    <= 3'd0;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_START;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^dado_entrada;
`endif
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx              = tx_q;
    assign uart_ocupado    = busy_q;
    assign envio_concluido = done_q;

endmodule

// File: tb/tb_uart_transmissor.sv
// tb/tb_uart_transmissor.sv - scoreboard bench for uart_transmissor, 10 clocks per bit
`timescale 1ns/1ps
module tb_uart_transmissor;
    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB         = PAR ? 11 : 10;
    localparam int FRAME_DONE = NB * CPB + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar_envio = 1'b0;
    logic [7:0] dado_entrada = 8'h00;
    logic       tx;
    logic       uart_ocupado;
    logic       envio_concluido;

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         abort;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   frames_done = 0;
    int   frames_seen = 0;
    int   spurious_done = 0;

    uart_transmissor #(
        .CLOCK_FREQ(1_000_000),
        .BAUD_RATE (100_000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .iniciar_envio  (iniciar_envio),
        .dado_entrada   (dado_entrada),
        .tx             (tx),
        .uart_ocupado   (uart_ocupado),
        .envio_concluido(envio_concluido)
    );

    always #5 clock = ~clock;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic exp_bit(input exp_t e, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return e.data[pos-1];
        if (pos == 9 && PAR) return e.par;
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] d, input logic p, input bit a);
        exp_q.push_back('{data: d, par: p, abort: a});
    endtask

    // Called at a negedge; returns at the negedge of frame cycle 1.
    task automatic send(input logic [7:0] b);
        iniciar_envio = 1'b1;
        dado_entrada  = b;
        @(negedge clock);
        iniciar_envio = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (envio_concluido !== 1'b1 && n < 400) begin
            @(negedge clock);
            n++;
            dado_entrada = 8'($urandom);
        end
        if (envio_concluido !== 1'b1) check(1'b0, "done_timeout", 32'(n), 32'(FRAME_DONE));
    endtask

    initial begin : monitor
        exp_t           e;
        logic [CPB-1:0] txs;
        logic [7:0]     got;
        int             busy_bad;
        bit             aborted;
        logic           eb;
        forever begin
            @(negedge clock);
            if (!reset && envio_concluido === 1'b1) spurious_done++;
            if (!reset && tx === 1'b0) begin
                frames_seen++;
                check(exp_q.size() != 0, "unexpected_frame", 32'(frames_seen), 32'(exp_q.size()));
                if (exp_q.size() == 0) begin
                    repeat (NB * CPB) @(negedge clock);
                end else begin
                    e        = exp_q.pop_front();
                    aborted  = 1'b0;
                    got      = '0;
                    busy_bad = 0;
                    txs      = '0;
                    for (int pos = 0; pos < NB; pos++) begin
                        for (int c = 0; c < CPB; c++) begin
                            if (pos != 0 || c != 0) @(negedge clock);
                            if (reset) aborted = 1'b1;
                            if (aborted) break;
                            txs[c] = tx;
                            if (uart_ocupado !== 1'b1 || envio_concluido !== 1'b0) busy_bad++;
                        end
                        if (aborted) break;
                        eb = exp_bit(e, pos);
                        check(txs === {CPB{eb}}, $sformatf("frame%0d_bit%0d", frames_seen, pos),
                              32'(txs), 32'({CPB{eb}}));
                        if (pos >= 1 && pos <= 8) got[pos-1] = txs[CPB/2];
                    end
                    if (aborted) begin
                        check(e.abort, "abort_expected", 32'(1), 32'(e.abort));
                        while (reset) @(negedge clock);
                    end else begin
                        check(!e.abort, "abort_missing", 32'(0), 32'(e.abort));
                        check(got === e.data, $sformatf("frame%0d_byte", frames_seen), 32'(got), 32'(e.data));
                        check(busy_bad == 0, "busy_during_frame", 32'(busy_bad), 32'(0));
                        @(negedge clock);
                        check(envio_concluido === 1'b1 && uart_ocupado === 1'b0, "done_pulse",
                              32'({envio_concluido, uart_ocupado}), 32'(2'b10));
                        frames_done++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        int bad;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check(tx === 1'b1, "reset_tx", 32'(tx), 32'(1));
        check(uart_ocupado === 1'b0, "reset_busy", 32'(uart_ocupado), 32'(0));
        check(envio_concluido === 1'b0, "reset_done", 32'(envio_concluido), 32'(0));
        reset = 1'b0;

        bad = 0;
        repeat (50) begin
            @(negedge clock);
            if (tx !== 1'b1 || uart_ocupado !== 1'b0 || envio_concluido !== 1'b0) bad++;
        end
        check(bad == 0, "idle_50", 32'(bad), 32'(0));

        push(8'hAE, 1'b1, 1'b0);
        send(8'hAE);
        check(uart_ocupado === 1'b1, "busy_cycle1", 32'(uart_ocupado), 32'(1));
        wait_done(n);
        check(n == FRAME_DONE, "done_latency_ae", 32'(n), 32'(FRAME_DONE));
        @(negedge clock);

        // Request mid-frame must be dropped entirely.
        push(8'hAE, 1'b1, 1'b0);
        send(8'hAE);
        repeat (34) @(negedge clock);
        iniciar_envio = 1'b1;
        dado_entrada  = 8'h55;
        @(negedge clock);
        iniciar_envio = 1'b0;
        wait_done(n);
        @(negedge clock);

        // Back-to-back: request in the envio_concluido cycle.
        push(8'hAE, 1'b1, 1'b0);
        send(8'hAE);
        wait_done(n);
        push(8'h81, 1'b0, 1'b0);
        send(8'h81);
        check(tx === 1'b0, "b2b_start", 32'(tx), 32'(0));
        wait_done(n);
        check(n == FRAME_DONE, "done_latency_81", 32'(n), 32'(FRAME_DONE));
        @(negedge clock);

        // Reset at frame cycle 45.
        push(8'hAE, 1'b1, 1'b1);
        send(8'hAE);
        repeat (44) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check(tx === 1'b1, "abort_tx", 32'(tx), 32'(1));
        check(uart_ocupado === 1'b0, "abort_busy", 32'(uart_ocupado), 32'(0));
        check(envio_concluido === 1'b0, "abort_done", 32'(envio_concluido), 32'(0));
        @(negedge clock);
        reset = 1'b0;
        bad = 0;
        repeat (120) begin
            @(negedge clock);
            if (envio_concluido !== 1'b0 || tx !== 1'b1) bad++;
        end
        check(bad == 0, "abort_quiet", 32'(bad), 32'(0));

        push(8'h0F, 1'b0, 1'b0);
        send(8'h0F);
        wait_done(n);
        check(n == FRAME_DONE, "done_latency_0f", 32'(n), 32'(FRAME_DONE));
        @(negedge clock);

        push(8'h03, 1'b0, 1'b0);
        send(8'h03);
        wait_done(n);
        check(n == FRAME_DONE, "done_latency_03", 32'(n), 32'(FRAME_DONE));

        repeat (60) @(negedge clock);
        check(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 32'(0));
        check(frames_done == 6, "frames_done", 32'(frames_done), 32'(6));
        check(spurious_done == 0, "spurious_done", 32'(spurious_done), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
